// File: rtl/ysyx_22041207_pkg.sv
// Shared types and constants for the IFU AXI read bridge.
// IFU_RD_TIMEOUT_EN adds the DRAIN state used after an R-channel timeout.
package ysyx_22041207_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_RESP = 3'd3
`ifdef IFU_RD_TIMEOUT_EN
    , ST_DRAIN = 3'd4
`endif
  } state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef struct packed {
    logic       ok;
    logic [2:0] arsize;
  } size_dec_t;

  // Only contiguous low-aligned lane masks map to a legal AXI transfer size.
  function automatic size_dec_t size_decode(input logic [7:0] mask);
    size_dec_t r;
    r.ok     = 1'b1;
    r.arsize = 3'd0;
    case (mask)
      8'h01:   r.arsize = 3'd0;
      8'h03:   r.arsize = 3'd1;
      8'h0F:   r.arsize = 3'd2;
      8'hFF:   r.arsize = 3'd3;
      default: r.ok     = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ysyx_22041207_ifu_axi_rd.sv
// Single-outstanding IF fetch to single-beat AXI4 read bridge.
// Define IFU_RD_TIMEOUT_EN to enable the R-channel watchdog and DRAIN state.
module ysyx_22041207_ifu_axi_rd
  import ysyx_22041207_pkg::*;
#(
  parameter int         ADDR_W = 64,
  parameter int         DATA_W = 64,
  parameter logic [3:0] AXI_ID = 4'h0
`ifdef IFU_RD_TIMEOUT_EN
  , parameter int       TIMEOUT_CYC = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_r_valid_i,
  output logic              rx_r_ready_o,
  input  logic [ADDR_W-1:0] rx_r_addr_i,
  input  logic [7:0]        rx_r_size_i,
  output logic [DATA_W-1:0] rx_data_read_o,
  output logic              rx_data_valid,
  input  logic              rx_data_ready,
  output logic              rx_r_err,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [3:0]        rid
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              alive_q;
  size_dec_t         size_dec;

  assign size_dec = size_decode(rx_r_size_i);

`ifdef IFU_RD_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       drain_q, drain_d;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    arsize_d = arsize_q;
    data_d   = data_q;
    err_d    = err_q;
`ifdef IFU_RD_TIMEOUT_EN
    cnt_d    = cnt_q;
    drain_d  = drain_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_r_valid_i && alive_q) begin
          addr_d   = rx_r_addr_i;
          arsize_d = size_dec.arsize;
          if (size_dec.ok) begin
            state_d = ST_AR;
          end else begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_AR: begin
        if (arready) begin
          state_d = ST_R;
`ifdef IFU_RD_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_R: begin
        if (rvalid) begin
          data_d  = rdata >> {addr_q[2:0], 3'b000};
          err_d   = (rresp != RESP_OKAY) || !rlast || (rid != AXI_ID);
          state_d = ST_RESP;
        end
`ifdef IFU_RD_TIMEOUT_EN
        // The AR was already issued, so a late beat must be swallowed in DRAIN.
        else if (cnt_q == TO_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          drain_d = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_RESP: begin
        if (rx_data_ready) begin
`ifdef IFU_RD_TIMEOUT_EN
          state_d = drain_q ? ST_DRAIN : ST_IDLE;
          drain_d = 1'b0;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef IFU_RD_TIMEOUT_EN
      ST_DRAIN: begin
        if (rvalid) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      arsize_q <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      alive_q  <= 1'b0;
`ifdef IFU_RD_TIMEOUT_EN
      cnt_q    <= '0;
      drain_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      arsize_q <= arsize_d;
      data_q   <= data_d;
      err_q    <= err_d;
      alive_q  <= 1'b1;
`ifdef IFU_RD_TIMEOUT_EN
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
`endif
    end
  end

  // alive_q keeps ready low through the reset cycle even though state is IDLE.
  assign rx_r_ready_o   = (state_q == ST_IDLE) && alive_q;
  assign rx_data_valid  = (state_q == ST_RESP);
  assign rx_data_read_o = data_q;
  assign rx_r_err       = err_q;

  assign arvalid = (state_q == ST_AR);
  assign araddr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = arsize_q;
  assign arburst = BURST_INCR;
`ifdef IFU_RD_TIMEOUT_EN
  assign rready  = (state_q == ST_R) || (state_q == ST_DRAIN);
`else
  assign rready  = (state_q == ST_R);
`endif

endmodule

// File: tb/tb_ysyx_22041207_ifu_axi_rd.sv
// Randomized self-checking bench for the IFU AXI read bridge with an inline AXI slave model.
module tb_ysyx_22041207_ifu_axi_rd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_r_valid_i;
  logic        rx_r_ready_o;
  logic [63:0] rx_r_addr_i;
  logic [7:0]  rx_r_size_i;
  logic [63:0] rx_data_read_o;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic        rx_r_err;
  logic        arvalid, arready;
  logic [63:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  ysyx_22041207_ifu_axi_rd dut (
    .clk(clk), .rst_n(rst_n),
    .rx_r_valid_i(rx_r_valid_i), .rx_r_ready_o(rx_r_ready_o),
    .rx_r_addr_i(rx_r_addr_i), .rx_r_size_i(rx_r_size_i),
    .rx_data_read_o(rx_data_read_o), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .rx_r_err(rx_r_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_rdy"},   64'(rx_r_ready_o),  64'd0);
    chk({pfx, "_vld"},   64'(rx_data_valid), 64'd0);
    chk({pfx, "_err"},   64'(rx_r_err),      64'd0);
    chk({pfx, "_data"},  rx_data_read_o,     64'd0);
    chk({pfx, "_arvld"}, 64'(arvalid),       64'd0);
    chk({pfx, "_araddr"}, araddr,            64'd0);
    chk({pfx, "_arsize"}, 64'(arsize),       64'd0);
    chk({pfx, "_rready"}, 64'(rready),       64'd0);
  endtask

  // One full fetch. Called and returns #1 after a rising edge.
  task automatic do_txn(input logic [63:0] addr, input logic [7:0] size,
                        input int ar_dly, input int r_dly,
                        input logic [63:0] data, input logic [1:0] resp,
                        input logic last, input logic [3:0] id, input int rdy_dly,
                        output int lat, output logic [63:0] got_data);
    logic        ok;
    logic [2:0]  exp_sz;
    logic        exp_err;
    logic [63:0] exp_data;
    int          exp_lat;
    int          t, ar_cnt, r_cnt;
    logic [63:0] held_data;
    logic        held_err;

    ok = 1'b1;
    exp_sz = 3'd0;
    case (size)
      8'h01: exp_sz = 3'd0;
      8'h03: exp_sz = 3'd1;
      8'h0F: exp_sz = 3'd2;
      8'hFF: exp_sz = 3'd3;
      default: ok = 1'b0;
    endcase
    exp_err  = !ok || (resp != 2'b00) || !last || (id != 4'h0);
    exp_data = ok ? (data / (64'd1 << (8 * int'(addr[2:0])))) : 64'd0;
    exp_lat  = ok ? 3 + ar_dly + r_dly : 1;

    chk("req_ready", 64'(rx_r_ready_o), 64'd1);
    rx_r_valid_i = 1'b1;
    rx_r_addr_i  = addr;
    rx_r_size_i  = size;
    @(posedge clk); #1;
    rx_r_valid_i = 1'b0;
    rx_r_addr_i  = {$urandom, $urandom};
    rx_r_size_i  = 8'($urandom);

    t = 0; ar_cnt = 0; r_cnt = 0;
    while (!rx_data_valid && t < 200) begin
      arready = 1'b0;
      rvalid  = 1'b0;
      if (arvalid) begin
        chk("araddr", araddr, {addr[63:3], 3'b000});
        if (ar_cnt == ar_dly) begin
          arready = 1'b1;
          chk("arsize", 64'(arsize), 64'(exp_sz));
          chk("arlen", 64'(arlen), 64'd0);
          chk("arburst", 64'(arburst), 64'd1);
          chk("arid", 64'(arid), 64'd0);
        end
        ar_cnt++;
      end
      if (rready) begin
        if (r_cnt == r_dly) begin
          rvalid = 1'b1;
          rdata  = data;
          rresp  = resp;
          rlast  = last;
          rid    = id;
        end
        r_cnt++;
      end
      @(posedge clk); #1;
      t++;
    end
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = {$urandom, $urandom};
    lat = t + 1;
    got_data = rx_data_read_o;

    if (t >= 200) begin
      chk("resp_timeout", 64'(t), 64'(exp_lat - 1));
    end else begin
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("ar_cycles", 64'(ar_cnt), ok ? 64'(ar_dly + 1) : 64'd0);
      chk("r_cycles", 64'(r_cnt), ok ? 64'(r_dly + 1) : 64'd0);
      chk("data", rx_data_read_o, exp_data);
      chk("err", 64'(rx_r_err), 64'(exp_err));
      held_data = rx_data_read_o;
      held_err  = rx_r_err;
      for (int i = 0; i < rdy_dly; i++) begin
        @(posedge clk); #1;
        chk("hold_vld", 64'(rx_data_valid), 64'd1);
        chk("hold_data", rx_data_read_o, held_data);
        chk("hold_err", 64'(rx_r_err), 64'(held_err));
        chk("hold_rdy", 64'(rx_r_ready_o), 64'd0);
        chk("hold_arvld", 64'(arvalid), 64'd0);
      end
      rx_data_ready = 1'b1;
      @(posedge clk); #1;
      rx_data_ready = 1'b0;
      chk("post_vld", 64'(rx_data_valid), 64'd0);
      chk("post_rdy", 64'(rx_r_ready_o), 64'd1);
    end
    n_txn++;
    $display("txn %0d addr=%h size=%h ardly=%0d rdly=%0d lat=%0d data=%h err=%b",
             n_txn, addr, size, ar_dly, r_dly, lat, got_data, rx_r_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int          lat;
    logic [63:0] got;
    logic [7:0]  sizes [4];
    logic [63:0] a;
    logic [7:0]  s;
    logic [1:0]  rs;
    logic        rl;
    logic [3:0]  ri;
    int          guard;

    sizes[0] = 8'h01; sizes[1] = 8'h03; sizes[2] = 8'h0F; sizes[3] = 8'hFF;
    rst_n = 1'b0;
    rx_r_valid_i = 1'b0; rx_r_addr_i = '0; rx_r_size_i = '0; rx_data_ready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b1; rid = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst_n = 1'b1;
    #1;
    chk("rdy_pre_edge", 64'(rx_r_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("rdy_after_rst", 64'(rx_r_ready_o), 64'd1);

    // Zero-wait fetch of a 32-bit word from the upper half.
    do_txn(64'h80000004, 8'h0F, 0, 0, 64'h00100073_00000413, 2'b00, 1'b1, 4'h0, 0, lat, got);
    chk("isa_word", 64'(got[31:0]), 64'h00100073);
    chk("lat_min", 64'(lat), 64'd3);

    do_txn(64'h80000000, 8'h0F, 3, 2, 64'h11223344_55667788, 2'b00, 1'b1, 4'h0, 1, lat, got);
    chk("lat_wait", 64'(lat), 64'd8);

    do_txn(64'h80000010, 8'hFF, 0, 0, 64'hDEADBEEF_CAFEF00D, 2'b10, 1'b1, 4'h0, 5, lat, got);
    do_txn(64'h80000020, 8'h07, 0, 0, 64'h0, 2'b00, 1'b1, 4'h0, 2, lat, got);
    chk("lat_badsize", 64'(lat), 64'd1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      a  = {$urandom, $urandom};
      s  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : sizes[$urandom_range(0, 3)];
      rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rl = ($urandom_range(0, 7) != 0);
      ri = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      do_txn(a, s, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
             rs, rl, ri, $urandom_range(0, 3), lat, got);
    end

    // Abort a fetch with reset while waiting on R.
    do_txn(64'h80000008, 8'hFF, 0, 0, 64'hFFFFFFFF_FFFFFFFF, 2'b00, 1'b1, 4'h0, 0, lat, got);
    rx_r_addr_i  = 64'h80001000;
    rx_r_size_i  = 8'h0F;
    rx_r_valid_i = 1'b1;
    @(posedge clk); #1;
    rx_r_valid_i = 1'b0;
    guard = 0;
    while (!rready && guard < 20) begin
      arready = arvalid;
      @(posedge clk); #1;
      guard++;
    end
    arready = 1'b0;
    chk("mid_r_rready", 64'(rready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("abort_rdy_pre", 64'(rx_r_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("abort_rdy", 64'(rx_r_ready_o), 64'd1);
    do_txn(64'h80000006, 8'h03, 1, 1, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1, 4'h0, 0, lat, got);
    chk("abort_next", 64'(got[15:0]), 64'h0123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22041207_ifu_axi_rd.md
# ysyx_22041207_ifu_axi_rd

Read-channel bridge directly downstream of the instruction-fetch stage. Accepts single fetch requests on the IF's simple address/data handshake and issues one single-beat AXI4 read per request. Returns the aligned instruction word with an error flag. One request is outstanding at a time. No caching or prefetch.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, AXI data width (fixed 64 in this revision)
- AXI_ID, 4'h0, constant ARID driven on every request
- TIMEOUT_CYC, 255, R-channel watchdog limit in cycles (used only with IFU_RD_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- rx_r_valid_i  in  1  IF request valid
- rx_r_ready_o  out  1  bridge accepts request
- rx_r_addr_i  in  64  fetch address
- rx_r_size_i  in  8  byte-lane mask (8'h01/03/0F/FF)
- rx_data_read_o  out  64  returned data, right-aligned by addr[2:0]
- rx_data_valid  out  1  response valid
- rx_data_ready  in  1  IF consumes response
- rx_r_err  out  1  response error, qualified by rx_data_valid
- arvalid/arready  out/in  1  AXI AR handshake
- araddr  out  64
- arid  out  4
- arlen  out  8
- arsize  out  3
- arburst  out  2
- rvalid/rready  in/out  1  AXI R handshake
- rdata  in  64
- rresp  in  2
- rlast  in  1
- rid  in  4

## Operation
- States: IDLE, AR, R, RESP; plus DRAIN when IFU_RD_TIMEOUT_EN is defined.
- IDLE:
  - rx_r_ready_o=1.
  - On rx_r_valid_i, latch address and size, then go to AR.
- AR:
  - arvalid=1. araddr is the latched address with bits [2:0] forced to 0.
  - arlen=0, arburst=INCR (2'b01), arid=AXI_ID.
  - AR payload is held stable until arready. On arready, go to R.
- R:
  - rready=1.
  - On the first rvalid beat, capture rdata>>(8*addr[2:0]).
  - Error is set when: rresp≠OKAY, or rlast=0, or rid≠AXI_ID. Then go to RESP.
- RESP:
  - rx_data_valid=1; data and error are held.
  - On rx_data_ready, go to IDLE.
- arsize mapping from the size mask: 01→0, 03→1, 0F→2, FF→3.
  - Any other mask: set error and skip AXI; go straight to RESP with data 0.
- rx_r_ready_o is 0 in every state except IDLE. Requests arriving in other states are not accepted.
- Reset values: rx_r_ready_o=0 (1 from the first cycle after reset release), rx_data_valid=0, rx_r_err=0, rx_data_read_o=0, arvalid=0, araddr=0, arsize=0, rready=0; state IDLE.
- Reset mid-transaction aborts the transaction without completion. The AXI slave must be reset by the same rst_n.

## Timing
- Request accepted at edge N; arvalid asserted from cycle N+1.
- Zero-wait slave (arready at N+1, rvalid at N+2): rx_data_valid rises at N+3. Minimum latency is 3 cycles.
- Each wait cycle on arready or rvalid adds exactly one cycle.
- Back-to-back requests: next acceptance no earlier than 1 cycle after the rx_data_ready handshake, i.e. at most one fetch per 4 cycles.
- rx_data_read_o and rx_r_err are registered and stable for the whole RESP state.

## Configuration
- IFU_RD_TIMEOUT_EN defined:
  - An 8-bit counter runs in R and clears on entry to R.
  - When it reaches TIMEOUT_CYC, the bridge reports rx_r_err=1 with data 0 via RESP, then goes to DRAIN.
  - DRAIN holds rready=1 and discards the stale beat, then returns to IDLE.
  - rx_r_ready_o stays 0 until the drain completes.
- IFU_RD_TIMEOUT_EN undefined: no counter and no DRAIN state; R waits indefinitely.

## Structure
- Shared package ysyx_22041207_pkg holds:
  - state enum
  - AXI constants: RESP_OKAY, BURST_INCR
  - size-mask→arsize decode function
- Sub-module: none. The aligner is a single shift expression inline.

## Test plan
- Zero-wait slave, addr 64'h80000004, size 8'h0F, rdata 64'h00100073_00000413 → rx_data_read_o[31:0]=32'h00100073, err=0, rx_data_valid at N+3.
- arready delayed 3 cycles and rvalid delayed 2 cycles → araddr stays 64'h80000000 throughout AR; data_valid at N+8.
- rresp=2'b10 (SLVERR) → rx_r_err=1 with data valid. Then rx_data_ready held low for 5 cycles → outputs stable and rx_r_ready_o=0.
- Size mask 8'h07 → no arvalid ever; rx_r_err=1 at N+1.
- rst_n pulsed low while in R → all outputs return to reset values immediately; IDLE accepts the next request.
- IFU_RD_TIMEOUT_EN with TIMEOUT_CYC=10 and no rvalid → err at cycle 10 of R. A later stale rvalid is consumed in DRAIN and not forwarded to IF.
